// File: rtl/fft_transpose_buffer.sv
// Corner-turn buffer: stores a ROWS x COLS frame row-major, replays it column-major in paced bursts.
// Optional sticky overrun flag output `err` when FFT_TPB_ERR_FLAG_EN is defined.
module fft_transpose_buffer #(
  parameter int WL    = 10,
  parameter int ROWS  = 80,
  parameter int COLS  = 80,
  parameter int BURST = 16,
  parameter int GAP   = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [WL-1:0]   in_r,
  input  logic [WL-1:0]   in_i,
  output logic            in_ready,
  output logic            out_valid,
  output logic [2*WL-1:0] out_data,
  output logic            frame_done,
  output logic            busy
`ifdef FFT_TPB_ERR_FLAG_EN
  ,
  output logic            err
`endif
);

  localparam int N      = ROWS * COLS;
  localparam int PERIOD = GAP + BURST;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int P_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int M_W    = (COLS > 1) ? $clog2(COLS + 1) : 1;
  localparam int PACE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic {
    ST_FILL,
    ST_READ
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              last_q, last_d;
  logic              frame_done_q, frame_done_d;
  logic [2*WL-1:0]   out_data_q;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  logic [2*WL-1:0]   ram [N];

  assign in_ready   = (state_q == ST_FILL);
  assign busy       = (state_q == ST_READ);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    p_d          = p_q;
    m_d          = m_q;
    pace_d       = pace_q;
    rd_cnt_d     = rd_cnt_q;
    last_d       = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = ADDR_W'(COLS * int'(p_q) + int'(m_q));

    case (state_q)
      ST_FILL: begin
        wr_en = in_valid;
        if (in_valid) begin
          if (wr_addr_q == ADDR_W'(N - 1)) begin
            wr_addr_d = '0;
            state_d   = ST_READ;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end

      ST_READ: begin
        pace_d = (pace_q == PACE_W'(PERIOD - 1)) ? '0 : pace_q + 1'b1;
        // Reads only in the burst window, and never beyond the last word of the frame.
        rd_en  = (pace_q >= PACE_W'(GAP)) && (rd_cnt_q != CNT_W'(N));
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          last_d   = (rd_cnt_q == CNT_W'(N - 1));
          if (p_q == P_W'(ROWS - 1)) begin
            p_d = '0;
            m_d = m_q + 1'b1;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
        // last_q marks the cycle the final word is on out_data; hand back to FILL right after.
        if (last_q) begin
          state_d      = ST_FILL;
          frame_done_d = 1'b1;
          p_d          = '0;
          m_d          = '0;
          pace_d       = '0;
          rd_cnt_d     = '0;
        end
      end

      default: state_d = ST_FILL;
    endcase

    out_valid_d = rd_en;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      wr_addr_q    <= '0;
      p_q          <= '0;
      m_q          <= '0;
      pace_q       <= '0;
      rd_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      p_q          <= p_d;
      m_q          <= m_d;
      pace_q       <= pace_d;
      rd_cnt_q     <= rd_cnt_d;
      out_valid_q  <= out_valid_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the storage array has no reset so it can map onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr_q] <= {in_r, in_i};
    end
  end

  // Synchronous read port; the register only loads on a read so out_data holds between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (rd_en) begin
      out_data_q <= ram[rd_addr];
    end
  end

`ifdef FFT_TPB_ERR_FLAG_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_fft_transpose_buffer.sv
// Scoreboard bench for fft_transpose_buffer: a frame-level model predicts every column word and its cycle.
module tb_fft_transpose_buffer;

  localparam int WL      = 10;
  localparam int ROWS    = 3;
  localparam int COLS    = 5;
  localparam int BURST   = 4;
  localparam int GAP     = 2;
  localparam int N       = ROWS * COLS;
  localparam int PERIOD  = GAP + BURST;
  localparam int TIMEOUT = 2000;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            in_valid = 1'b0;
  logic [WL-1:0]   in_r     = '0;
  logic [WL-1:0]   in_i     = '0;
  logic            in_ready;
  logic            out_valid;
  logic [2*WL-1:0] out_data;
  logic            frame_done;
  logic            busy;
`ifdef FFT_TPB_ERR_FLAG_EN
  logic            err;
`endif

  always #5 clk = ~clk;

  fft_transpose_buffer #(
    .WL(WL), .ROWS(ROWS), .COLS(COLS), .BURST(BURST), .GAP(GAP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_r      (in_r),
    .in_i      (in_i),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .frame_done(frame_done),
    .busy      (busy)
`ifdef FFT_TPB_ERR_FLAG_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [2*WL-1:0] data;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: collects a frame, then predicts column-major words and their output cycles.
  logic [2*WL-1:0] frame [N];
  int   acc     = 0;
  bit   rd_mode = 0;
  int   fd_cyc  = -1;
  bit   err_m   = 0;
  int   sched_j;
  int   sched_k;
  exp_t sched_e;

  always @(negedge clk) begin
    if (rst) begin
      acc     = 0;
      rd_mode = 0;
      fd_cyc  = -1;
      err_m   = 0;
      exp_q.delete();
    end else begin
      if (rd_mode && cyc == fd_cyc) rd_mode = 0;
      check("frame_done", frame_done, cyc == fd_cyc);
      check("in_ready", in_ready, !rd_mode);
      check("busy", busy, rd_mode);
`ifdef FFT_TPB_ERR_FLAG_EN
      check("err", err, err_m);
      if (in_valid && rd_mode) err_m = 1;
`endif
      if (in_valid && !rd_mode) begin
        frame[acc] = {in_r, in_i};
        acc++;
        if (acc == N) begin
          // Read slot j counts from the first READ cycle; slots with j mod PERIOD >= GAP carry a word.
          sched_j = 0;
          sched_k = 0;
          while (sched_k < N) begin
            if ((sched_j % PERIOD) >= GAP) begin
              sched_e.data = frame[COLS * (sched_k % ROWS) + sched_k / ROWS];
              sched_e.cyc  = cyc + 2 + sched_j;
              exp_q.push_back(sched_e);
              sched_k++;
            end
            sched_j++;
          end
          fd_cyc  = cyc + 2 + sched_j;
          acc     = 0;
          rd_mode = 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  logic [2*WL-1:0] last_data;
  exp_t            mon_e;

  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missing_out_valid", 0, 1);
        void'(exp_q.pop_front());
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_valid_cycle", cyc, mon_e.cyc);
        end
        last_data = out_data;
      end else begin
        check("out_data_hold", out_data, last_data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_word(input logic [WL-1:0] r, input logic [WL-1:0] i);
    in_valid = 1'b1;
    in_r     = r;
    in_i     = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input int base, input int max_gap);
    for (int k = 0; k < N; k++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      if (rnd) drive_word(WL'($urandom), WL'($urandom));
      else     drive_word(WL'(base + k), '0);
    end
  endtask

  task automatic wait_frame_done(input bit pulse_drops);
    for (int t = 0; t < TIMEOUT; t++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (frame_done) return;
      if (pulse_drops && busy && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        in_r     = WL'(99);
        in_i     = WL'(99);
      end
    end
    check("frame_done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_busy", busy, 0);
`ifdef FFT_TPB_ERR_FLAG_EN
    check("reset_err", err, 0);
`endif
    idle(2);

    // Sequential frame with stray words pulsed in during READ.
    send_frame(1'b0, 0, 0);
    wait_frame_done(1'b1);

    // Next frame starts in the frame_done cycle itself.
    send_frame(1'b1, 0, 0);
    wait_frame_done(1'b0);
`ifdef FFT_TPB_ERR_FLAG_EN
    check("err_sticky", err, 1);
`endif

    // Abort a partial frame with a one-cycle reset; only the new frame may appear.
    for (int k = 0; k < 7; k++) drive_word(WL'(500 + k), WL'(k));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
`ifdef FFT_TPB_ERR_FLAG_EN
    check("err_cleared", err, 0);
`endif
    send_frame(1'b0, 100, 0);
    wait_frame_done(1'b0);

    // Random data, random input gaps, random dropped words.
    repeat (3) begin
      idle($urandom_range(0, 5));
      send_frame(1'b1, 0, 3);
      wait_frame_done(1'b1);
    end

    idle(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
